// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
//   RESP_*      : AXI response codes used on bresp/rresp
//   WR_*        : write-path slot occupancy states (bit0 = AW held, bit1 = W held)
//   RD_*        : read-path states
//   clog2()     : ceiling log2 for elaboration-time width math
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] WR_EMPTY   = 2'b00;
  localparam logic [1:0] WR_HAVE_AW = 2'b01;
  localparam logic [1:0] WR_HAVE_W  = 2'b10;
  localparam logic [1:0] WR_FULL    = 2'b11;

  localparam logic RD_IDLE  = 1'b0;
  localparam logic RD_VALID = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational register-address decoder.
//   addr     : AXI byte address
//   index    : register index ((addr - BASE_ADDR) >> log2(bytes per word))
//   in_range : address at or above BASE_ADDR and index below NUM_REGS
// Low address bits within a word are ignored.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned IDX_WIDTH  = clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_WIDTH-1:0]  index,
  output logic                  in_range
);

  localparam int unsigned ADDR_LSB = clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] scaled;

  always_comb begin
    offset   = addr - BASE_ADDR;
    scaled   = offset >> ADDR_LSB;
    index    = scaled[IDX_WIDTH-1:0];
    // The explicit lower-bound test stops addresses below BASE_ADDR from
    // wrapping around through the subtraction into a small index.
    in_range = (addr >= BASE_ADDR) && (scaled < NUM_REGS_A);
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite register-bank slave.
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   aw*/w*/b*               : AXI4-Lite write address, data and response channels
//   ar*/r*                  : AXI4-Lite read address and data channels
//   reg_q                   : all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse                : one-cycle pulse per register after a successful write
// AW and W are captured into independent one-entry slots; the write commits
// once both are held and the B channel is free. Out-of-range or read-only
// accesses return SLVERR.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]              wr_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [1:0]            wr_state;
  logic [1:0]            wr_next;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  wr_ok;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic                  wr_in_range;

  logic                  rd_state;
  logic                  ar_hs;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  rd_in_range;

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wr_decode (
    .addr     (aw_addr_q),
    .index    (wr_idx),
    .in_range (wr_in_range)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rd_decode (
    .addr     (araddr),
    .index    (rd_idx),
    .in_range (rd_in_range)
  );

  // ---------------------------------------------------------------- write path
  always_comb begin
    aw_hs  = awvalid && awready;
    w_hs   = wvalid && wready;
    wr_ok  = wr_in_range && !RO_MASK[wr_idx];
    commit = (wr_state == WR_FULL) && (!bvalid || bready);

    wr_next = wr_state;
    case (wr_state)
      WR_EMPTY: begin
        if (aw_hs && w_hs) wr_next = WR_FULL;
        else if (aw_hs)    wr_next = WR_HAVE_AW;
        else if (w_hs)     wr_next = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)   wr_next = WR_FULL;
      WR_HAVE_W:  if (aw_hs)  wr_next = WR_FULL;
      WR_FULL:    if (commit) wr_next = WR_EMPTY;
      default:    wr_next = WR_EMPTY;
    endcase
  end

  // Readies are registered copies of "slot empty" in the next state, so they
  // drop on the handshake edge and rise again on the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state  <= WR_EMPTY;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      wr_state <= wr_next;
      awready  <= (wr_next == WR_EMPTY) || (wr_next == WR_HAVE_W);
      wready   <= (wr_next == WR_EMPTY) || (wr_next == WR_HAVE_AW);

      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end

      wr_pulse <= '0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) wr_pulse[wr_idx] <= 1'b1;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (commit && wr_ok) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb_q[b]) regs[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // ----------------------------------------------------------------- read path
  assign ar_hs  = arvalid && arready;
  assign rvalid = (rd_state == RD_VALID);

  // rdata samples regs before any same-edge commit lands, so a read racing a
  // write to the same register returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_VALID;
            arready  <= 1'b0;
            rdata    <= rd_in_range ? regs[rd_idx] : '0;
            rresp    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready  <= 1'b1;
          end
        end
        RD_VALID: begin
          if (rready) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite register-bank slave. It is the successor to the fixed 16×32 slave. Generalised in data width and register count, it adds:
- independent AW/W acceptance
- SLVERR responses for bad or read-only addresses
- strict valid/ready backpressure compliance
- a hardware-side register view with per-register write strobes

It sits behind the AXI-Lite interconnect as a control/status register block for a peripheral.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, data width; 32 or 64 only.
NUM_REGS, 16, number of registers; power of 2, range 2..256.
BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to NUM_REGS*DATA_WIDTH/8.
RESET_VAL, 0, reset value of every register (DATA_WIDTH bits).
RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only from AXI.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read valid
rready  in  1  read ready
reg_q  out  NUM_REGS*DATA_WIDTH  all registers, flattened, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_REGS  one-cycle pulse per successful register write

Behaviour:
Address decode:
- ADDR_LSB = log2(DATA_WIDTH/8).
- Index = (addr - BASE_ADDR) >> ADDR_LSB.
- A write or read is in range iff addr >= BASE_ADDR and index < NUM_REGS.
- Addresses below BASE_ADDR must not wrap into range.
- Low ADDR_LSB address bits are ignored.

Reset (asynchronous):
- awready, wready, arready, bvalid, rvalid = 0.
- bresp = rresp = 2'b00; rdata = 0; wr_pulse = 0.
- All registers = RESET_VAL.
- In-flight AW, W, B and R state is discarded; no partial write occurs.
- awready, wready and arready rise on the first clock edge after reset deasserts.

Write path:
- AW and W each have a one-entry holding slot and are accepted independently, in either order.
- awready = AW slot empty; wready = W slot empty. Both are registered. Each drops on the edge of its handshake.
- Commit edge: the first edge where both slots are full and (bvalid==0 or bready==1).
  - Byte lanes with wstrb set are written.
  - bvalid = 1, bresp set.
  - Both slots clear, so awready and wready return to 1.
- Latency: with AW and W handshaking on edge E, the commit happens on E+1. bvalid and the new reg_q are visible after E+1.
- bresp:
  - 2'b00 OKAY for an in-range, writable register.
  - 2'b10 SLVERR if out of range or RO_MASK[index] set; the register is then unchanged.
- bvalid and bresp stay stable until the bready handshake.
- wstrb == 0 in range gives OKAY, no bytes change, and wr_pulse still fires.
- wr_pulse[index] is high for exactly the cycle following a commit edge, OKAY writes only.

Read path:
- arready = !rvalid (registered).
- AR handshake on edge E: rdata, rresp and rvalid are loaded on E, so rvalid is visible the following cycle.
- rdata, rresp and rvalid hold until the rready handshake; arready returns to 1 on that edge.
- Out-of-range read: rdata = 0, rresp = 2'b10.
- Read-only registers read normally with OKAY.

Concurrency:
- Read and write paths are fully independent.
- If an AR handshake and a write commit to the same register fall on the same edge, the read returns the pre-write value.

Throughput: one write per 2 cycles, one read per 2 cycles.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - clog2 helper function
  - write and read state constants
- Sub-module axi_lite_addr_decode: combinational (addr → index, in_range), one instance each for the read and write paths.

Test Plan:
1. Reset then AW 0x08 and W 0xDEADBEEF, wstrb 0xF, in the same cycle → bresp 00; reg_q register 2 = 0xDEADBEEF; wr_pulse = 16'h0004 for one cycle; read 0x08 returns 0xDEADBEEF, rresp 00.
2. W issued 3 cycles before AW (addr 0x0C, data 0x11223344, wstrb 4'b0101) with register 3 = 0 → wready drops, awready stays high; after AW, register 3 = 0x00220044, bresp 00.
3. Write to 0x40 (NUM_REGS=16), then read 0x40 → bresp 10 with registers unchanged; read gives rdata 0, rresp 10.
4. RO_MASK = 16'h0001: write 0x55 to 0x00 → bresp 10, register 0 keeps RESET_VAL, wr_pulse stays 0.
5. Hold bready = 0 for 5 cycles with a second AW/W pending → bvalid and bresp stable, second commit waits, awready and wready stay 0. After bready, the second response follows.
6. Assert reset with AW held and W not yet received → all readies 0 and valids 0. After release, no register has changed and the next full write completes normally.
7. DATA_WIDTH=64, NUM_REGS=8: write 0x18 with wstrb 8'hF0 and data 0x0123456789ABCDEF → register 3 upper 32 bits = 0x01234567, lower bits unchanged.
